ta_issue_ctrl: RTL

TA_ISSUE_CTRL -- requirements
Module: ta_issue_ctrl

---
 rtl/ta_issue_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ta_issue_ctrl.sv
// ============================================================================
//  Module   : ta_issue_ctrl
//  Purpose  : Round-robin issue controller that feeds a two-stage aligner and
//             returns aligned words in acceptance order, tagged with their
//             requester id. Optional macro TA_ISSUE_STATS_EN adds per-requester
//             saturating handshake counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ta_issue_ctrl #(
    parameter int ALIGN_LAT = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       req0_valid_i,
    input  logic       req1_valid_i,
    input  logic [5:0] req0_data_i,
    input  logic [5:0] req1_data_i,
    output logic       req0_ready_o,
    output logic       req1_ready_o,
    output logic [2:0] msb_o,
    output logic [2:0] lsb_o,
    input  logic [5:0] dout_i,
    output logic       rsp_valid_o,
    output logic [5:0] rsp_data_o,
    output logic       rsp_id_o,
    output logic       busy_o
`ifdef TA_ISSUE_STATS_EN
    ,
    output logic [15:0] cnt0_o,
    output logic [15:0] cnt1_o
`endif
);

    localparam int c_DEPTH = ALIGN_LAT + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;
    logic [c_DEPTH-1:0] r_tag_v;
    logic [c_DEPTH-1:0] r_tag_id;
    logic [2:0]         r_s1_lsb;
    logic [2:0]         r_msb;
    logic [2:0]         r_lsb;
    logic               r_rsp_valid;
    logic [5:0]         r_rsp_data;
    logic               r_rsp_id;

    logic       w_any_valid;
    logic       w_grant_id;
    logic       w_issue;
    logic       w_hs;
    logic       w_inflight;
    logic [5:0] w_word;

    // Contention goes to whichever requester did not win the last handshake.
    always_comb begin
        w_any_valid = req0_valid_i | req1_valid_i;
        w_grant_id  = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            w_grant_id = ~r_last;
        end else if (req1_valid_i) begin
            w_grant_id = 1'b1;
        end
    end

    assign w_issue      = (r_state == ST_RUN) && en_i;
    assign w_hs         = w_issue && w_any_valid;
    assign w_word       = w_grant_id ? req1_data_i : req0_data_i;
    assign w_inflight   = |r_tag_v;
    assign req0_ready_o = w_issue && w_any_valid && !w_grant_id;
    assign req1_ready_o = w_issue && w_any_valid && w_grant_id;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en_i) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!en_i) w_state_nxt = w_inflight ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (en_i)             w_state_nxt = ST_RUN;
                else if (!w_inflight) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tag bit k marks a word that was accepted k edges ago; the oldest slot
    // lines up with the edge at which the aligner output is valid.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_last      <= 1'b1;
            r_tag_v     <= '0;
            r_tag_id    <= '0;
            r_s1_lsb    <= 3'd0;
            r_msb       <= 3'd0;
            r_lsb       <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 6'd0;
            r_rsp_id    <= 1'b0;
        end else begin
            r_tag_v  <= {r_tag_v[c_DEPTH-2:0], w_hs};
            r_tag_id <= {r_tag_id[c_DEPTH-2:0], w_grant_id};
            r_msb    <= w_hs ? w_word[5:3] : 3'd0;
            r_lsb    <= r_tag_v[0] ? r_s1_lsb : 3'd0;
            if (w_hs) begin
                r_last   <= w_grant_id;
                r_s1_lsb <= w_word[2:0];
            end
            r_rsp_valid <= r_tag_v[ALIGN_LAT];
            if (r_tag_v[ALIGN_LAT]) begin
                r_rsp_data <= dout_i;
                r_rsp_id   <= r_tag_id[ALIGN_LAT];
            end
        end
    end

    assign msb_o       = r_msb;
    assign lsb_o       = r_lsb;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_id_o    = r_rsp_id;
    assign busy_o      = (r_state != ST_IDLE);

`ifdef TA_ISSUE_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt0 <= 16'd0;
            r_cnt1 <= 16'd0;
        end else if (w_hs) begin
            if (!w_grant_id && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_grant_id && r_cnt1 != 16'hFFFF)  r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign cnt0_o = r_cnt0;
    assign cnt1_o = r_cnt1;
`endif

endmodule

`default_nettype wire
